mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration of mult/multu, in cycles (legal 1..15).
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of div/divu, in cycles (legal 1..15).
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
REQ-005 Port E_start, input, 1 bit: an MD instruction is in the E stage this cycle.
REQ-006 Port E_op, input, 3 bits: operation code; 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are no-op.
REQ-007 Port E_A, input, 32 bits: forwarded rs operand.
REQ-008 Port E_B, input, 32 bits: forwarded rt operand.
REQ-009 Port D_md_use, input, 1 bit: the D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
REQ-010 Port busy, output, 1 bit: a multi-cycle operation is in progress.
REQ-011 Port stall, output, 1 bit: freeze F/D and insert a bubble into E.
REQ-012 Port HI, output, 32 bits: architectural HI register.
REQ-013 Port LO, output, 32 bits: architectural LO register.

Function
REQ-014 The controller has two states, IDLE and RUN, plus a 4-bit down-counter cnt and 32-bit pending registers pHI and pLO.
REQ-015 In IDLE, E_start=1 with op 0-3 latches the result into pHI/pLO, loads cnt with MULT_CYCLES or DIV_CYCLES, and moves to RUN at that edge.
REQ-016 mult: {pHI,pLO} = signed E_A*E_B (64-bit). multu: unsigned product.
REQ-017 div: pLO = signed quotient, pHI = signed remainder, both truncating toward zero, with the remainder taking the sign of the dividend. divu: unsigned quotient and remainder.
REQ-018 div/divu with E_B=0: the operation still runs for DIV_CYCLES, and HI/LO keep their previous values at completion.
REQ-019 busy=1 exactly while in RUN; busy is registered, so it is high for exactly N cycles starting the cycle after the start edge.
REQ-020 In RUN, cnt decrements each cycle; at the edge where cnt==1, HI<=pHI, LO<=pLO, and the state returns to IDLE.
REQ-021 HI/LO show the old values throughout RUN; the new values are visible the cycle after busy falls.
REQ-022 mthi (op 4) or mtlo (op 5) with E_start=1 in IDLE writes E_A to HI or LO at that edge; busy stays 0.
REQ-023 E_start=1 while in RUN is ignored entirely: no state, counter, HI or LO change. The pipeline never issues this because of stall.
REQ-024 stall = D_md_use & (busy | (E_start & E_op<=3)); combinational, with no dependence on the current edge's update.
REQ-025 Ops 6 and 7 have no effect and do not assert stall.
REQ-026 Back-to-back operation: a new start is accepted in the first cycle after busy falls.

Reset
REQ-027 reset=0 at an edge forces IDLE, cnt=0, busy=0, HI=0, LO=0, pHI=0, pLO=0, including mid-operation; the pending result is discarded.
REQ-028 On reset, stall drops as soon as busy=0, provided E_start is not asserted with ops 0-3.

Configuration
REQ-029 Macro MDU_DIV_EN: when defined, div/divu behave as in REQ-015 to REQ-018.
REQ-030 When MDU_DIV_EN is undefined, ops 2 and 3 behave as no-ops (like ops 6 and 7), no divider logic is synthesized, and DIV_CYCLES is unused.

Verification
REQ-031 mult with E_A=0xFFFFFFFE (-2) and E_B=3 -> busy high for exactly 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-032 divu with E_A=100 and E_B=7 -> busy high for 10 cycles, then LO=14 and HI=2; div with E_A=-7 and E_B=2 -> LO=0xFFFFFFFD and HI=0xFFFFFFFF.
REQ-033 div with E_B=0 after mthi 0x11 and mtlo 0x22 -> busy for 10 cycles, then HI=0x11 and LO=0x22 are unchanged.
REQ-034 mult start, then D_md_use=1 (mflo) held -> stall=1 from the start cycle through the last busy cycle and 0 the next cycle, at which point LO shows the product.
REQ-035 reset=0 asserted on the 3rd busy cycle of multu 5x5 -> the next cycle has busy=0, HI=0 and LO=0, and no later write of 25 occurs.
REQ-036 Build without MDU_DIV_EN; divu 100/7 -> busy stays 0, stall stays 0, and HI/LO are unchanged.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// Bundle between the E/D pipeline stages and the multiply/divide controller.
// The pipeline side uses modport master and the controller uses modport slave.
interface mdu_ctrl_if;
  logic        E_start;
  logic [2:0]  E_op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output E_start, E_op, E_A, E_B, D_md_use,
                  input  busy, stall, HI, LO);
  modport slave  (input  E_start, E_op, E_A, E_B, D_md_use,
                  output busy, stall, HI, LO);
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle HI/LO controller: the result is latched at start and is committed after a fixed busy window.
// Define MDU_DIV_EN to build the divider (div/divu); without it, ops 2 and 3 are no-ops.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave md
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic        p_wr;
  logic        is_mul;
  logic        is_div;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  // Widening both operands to 64 bits gives a correct low half for signed and unsigned products alike
  assign is_mul = (md.E_op == 3'd0) || (md.E_op == 3'd1);
  assign mul_a  = md.E_op[0] ? {32'b0, md.E_A} : {{32{md.E_A[31]}}, md.E_A};
  assign mul_b  = md.E_op[0] ? {32'b0, md.E_B} : {{32{md.E_B[31]}}, md.E_B};
  assign prod   = mul_a * mul_b;

`ifdef MDU_DIV_EN
  logic signed [32:0] div_a;
  logic signed [32:0] div_b;
  logic signed [32:0] div_q;
  logic signed [32:0] div_r;
  logic               unused_div_msb;

  // A 33-bit signed divider handles divu via zero extension and keeps -2^31 / -1 well defined
  assign is_div = (md.E_op == 3'd2) || (md.E_op == 3'd3);
  assign div_a  = md.E_op[0] ? {1'b0, md.E_A} : {md.E_A[31], md.E_A};
  assign div_b  = md.E_op[0] ? {1'b0, md.E_B} : {md.E_B[31], md.E_B};

  always_comb begin
    div_q = '0;
    div_r = '0;
    if (md.E_B != 32'd0) begin
      div_q = div_a / div_b;
      div_r = div_a % div_b;
    end
  end

  assign quo            = div_q[31:0];
  assign rem            = div_r[31:0];
  assign unused_div_msb = div_q[32] ^ div_r[32];
`else
  logic unused_div_cycles;

  assign is_div            = 1'b0;
  assign quo               = 32'd0;
  assign rem               = 32'd0;
  assign unused_div_cycles = (DIV_CYCLES != 0);
`endif

  assign md.stall = md.D_md_use & (md.busy | (md.E_start & (is_mul | is_div)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      md.busy <= 1'b0;
      md.HI   <= 32'd0;
      md.LO   <= 32'd0;
      p_hi    <= 32'd0;
      p_lo    <= 32'd0;
      p_wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md.E_start) begin
            if (is_mul) begin
              p_hi    <= prod[63:32];
              p_lo    <= prod[31:0];
              p_wr    <= 1'b1;
              cnt     <= 4'(MULT_CYCLES);
              state   <= RUN;
              md.busy <= 1'b1;
            end else if (is_div) begin
              // Divide by zero still occupies the unit but leaves HI/LO untouched
              p_hi    <= rem;
              p_lo    <= quo;
              p_wr    <= (md.E_B != 32'd0);
              cnt     <= 4'(DIV_CYCLES);
              state   <= RUN;
              md.busy <= 1'b1;
            end else if (md.E_op == 3'd4) begin
              md.HI <= md.E_A;
            end else if (md.E_op == 3'd5) begin
              md.LO <= md.E_A;
            end
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (p_wr) begin
              md.HI <= p_hi;
              md.LO <= p_lo;
            end
            state   <= IDLE;
            md.busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized scoreboard bench for mdu_ctrl: stimulus queues expected HI/LO, a monitor checks busy, stall and commits.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .md   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    logic [31:0] new_hi;
    logic [31:0] new_lo;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          rem_cycles = 0;
  logic [31:0] ref_hi = 32'd0;
  logic [31:0] ref_lo = 32'd0;
  bit          mon_on = 1'b0;
  bit          prev_busy = 1'b0;

  function automatic bit multi_op(logic [2:0] op);
`ifdef MDU_DIV_EN
    return op <= 3'd3;
`else
    return op <= 3'd1;
`endif
  endfunction

  function automatic int op_cycles(logic [2:0] op);
    return (op <= 3'd1) ? 5 : 10;
  endfunction

  // Reference results straight from the arithmetic definitions
  function automatic exp_t model(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] hi, logic [31:0] lo);
    exp_t             e;
    longint           sp;
    longint unsigned  up;
    int               sq;
    int               sr;
    e.old_hi = hi;
    e.old_lo = lo;
    e.new_hi = hi;
    e.new_lo = lo;
    if (op == 3'd0) begin
      sp = longint'(int'(a)) * longint'(int'(b));
      e.new_hi = sp[63:32];
      e.new_lo = sp[31:0];
    end else if (op == 3'd1) begin
      up = longint'(a) * longint'(b);
      e.new_hi = up[63:32];
      e.new_lo = up[31:0];
    end else if (op == 3'd2 && b != 32'd0) begin
      sq = int'(a) / int'(b);
      sr = int'(a) % int'(b);
      e.new_lo = sq;
      e.new_hi = sr;
    end else if (op == 3'd3 && b != 32'd0) begin
      e.new_lo = a / b;
      e.new_hi = a % b;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Abstract occupancy model: a busy countdown that ignores starts while running
  always @(posedge clk) begin
    if (!reset) rem_cycles = 0;
    else if (rem_cycles > 0) rem_cycles = rem_cycles - 1;
    else if (bus.E_start && multi_op(bus.E_op)) rem_cycles = op_cycles(bus.E_op);
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_on) begin
        checkOutput("busy", 32'(bus.busy), 32'(rem_cycles > 0));
        checkOutput("stall", 32'(bus.stall),
                    32'(bus.D_md_use && (rem_cycles > 0 || (bus.E_start && multi_op(bus.E_op)))));
        if (bus.busy === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_busy: busy with no queued operation at %0t", $time);
          end else begin
            checkOutput("hi_during_run", bus.HI, sb[0].old_hi);
            checkOutput("lo_during_run", bus.LO, sb[0].old_lo);
          end
        end else if (prev_busy) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_commit: busy fell with no queued operation at %0t", $time);
          end else begin
            e = sb.pop_front();
            checkOutput("hi_commit", bus.HI, e.new_hi);
            checkOutput("lo_commit", bus.LO, e.new_lo);
          end
        end
        prev_busy = (bus.busy === 1'b1);
      end
    end
  end

  // Called and returns at a falling edge; the start is sampled on the following rising edge
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit md_use, input bit wait_idle);
    exp_t e;
    bit   accepted;
    accepted     = (rem_cycles == 0);
    bus.E_start  = 1'b1;
    bus.E_op     = op;
    bus.E_A      = a;
    bus.E_B      = b;
    bus.D_md_use = md_use;
    if (accepted && multi_op(op)) begin
      e = model(op, a, b, ref_hi, ref_lo);
      sb.push_back(e);
      ref_hi = e.new_hi;
      ref_lo = e.new_lo;
    end else if (accepted && op == 3'd4) begin
      ref_hi = a;
    end else if (accepted && op == 3'd5) begin
      ref_lo = a;
    end
    @(negedge clk);
    bus.E_start = 1'b0;
    if (accepted && !multi_op(op)) begin
      checkOutput("hi_immediate", bus.HI, ref_hi);
      checkOutput("lo_immediate", bus.LO, ref_lo);
    end
    if (wait_idle) waitIdle();
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (rem_cycles != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rem_cycles != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: unit still busy after 40 cycles");
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bus.E_start  = 1'b0;
    bus.E_op     = 3'd0;
    bus.E_A      = 32'd0;
    bus.E_B      = 32'd0;
    bus.D_md_use = 1'b0;
    reset        = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_hi", bus.HI, 32'd0);
    checkOutput("reset_lo", bus.LO, 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    reset  = 1'b1;
    mon_on = 1'b1;

    // Directed corner cases
    applyStimulus(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);
    checkOutput("mult_neg_hi", bus.HI, 32'hFFFF_FFFF);
    checkOutput("mult_neg_lo", bus.LO, 32'hFFFF_FFFA);
    applyStimulus(3'd3, 32'd100, 32'd7, 1'b1, 1'b1);
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    applyStimulus(3'd4, 32'h11, 32'd0, 1'b0, 1'b1);
    applyStimulus(3'd5, 32'h22, 32'd0, 1'b0, 1'b1);
    applyStimulus(3'd2, 32'd55, 32'd0, 1'b0, 1'b1);
    checkOutput("divzero_hi", bus.HI, 32'h11);
    checkOutput("divzero_lo", bus.LO, 32'h22);
    applyStimulus(3'd0, 32'd1234, 32'd5678, 1'b1, 1'b1);
    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    applyStimulus(3'd6, 32'd9, 32'd9, 1'b1, 1'b1);
    applyStimulus(3'd7, 32'd9, 32'd9, 1'b1, 1'b1);

    // Starts issued while running must be ignored
    applyStimulus(3'd0, 32'd7, 32'd6, 1'b1, 1'b0);
    applyStimulus(3'd4, 32'hDEAD, 32'd0, 1'b1, 1'b0);
    applyStimulus(3'd1, 32'd3, 32'd3, 1'b0, 1'b1);

    // Reset during the third busy cycle discards the pending product
    applyStimulus(3'd1, 32'd5, 32'd5, 1'b0, 1'b0);
    sb[sb.size() - 1].new_hi = 32'd0;
    sb[sb.size() - 1].new_lo = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
    ref_hi = 32'd0;
    ref_lo = 32'd0;
    repeat (10) begin
      @(negedge clk);
      checkOutput("post_reset_lo", bus.LO, 32'd0);
    end

    // Randomized traffic, some starts deliberately overlapping busy windows
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom());
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : 32'($urandom()));
      if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      applyStimulus(op, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("final_hi", bus.HI, ref_hi);
    checkOutput("final_lo", bus.LO, ref_lo);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
